adc_capture: RTL and testbench

Acquisition front end between the 8-bit parallel ADC pins and the processor-system peripheral bus.
- Generates adc_clk from hclk and registers each ADC sample once per conversion.
- Runs a pre/post-trigger acquisition into an on-chip circular buffer.
- Presents the captured record to software through a registered read port, with done/irq status.

---
 rtl/adc_capture_pkg.sv | 17 +
 rtl/capture_ram.sv | 29 ++
 rtl/adc_capture.sv | 198 +++++++++++++++++++
 tb/tb_adc_capture.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC acquisition front end.
package adc_capture_pkg;

   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = 3'd0,
      ST_PRE       = 3'd1,
      ST_WAIT_TRIG = 3'd2,
      ST_POST      = 3'd3,
      ST_DONE      = 3'd4
   } state_e;

   localparam logic TRIG_RISE = 1'b0;
   localparam logic TRIG_FALL = 1'b1;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read-first read port.
module capture_ram #(
   parameter int unsigned AW = 10,
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [DW-1:0] mem [DEPTH];

   // Array carries no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata <= '0;
      else        rdata <= mem[raddr];
   end

endmodule

// File: rtl/adc_capture.sv
// ADC clock generation, pre/post-trigger capture into a circular buffer,
// and a trigger-relative read port for software.
module adc_capture
   import adc_capture_pkg::*;
#(
   parameter int unsigned AW    = 10,
   parameter int unsigned DW    = 8,
   parameter int unsigned DIV_W = 8
) (
   input  logic             hclk,
   input  logic             reset_n,
   input  logic [DW-1:0]    adc_data,
   output logic             adc_clk,
   input  logic [DIV_W-1:0] div_half,
   input  logic             arm,
   input  logic             abort,
   input  logic             force_trig,
   input  logic             trig_edge,
   input  logic [DW-1:0]    trig_level,
   input  logic [AW-1:0]    pretrig,
   output logic             busy,
   output logic             done,
   output logic             irq,
   input  logic [AW-1:0]    rd_addr,
   output logic [DW-1:0]    rd_data,
   output logic [AW-1:0]    trig_pos
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [DIV_W-1:0] div_cnt, div_cur, div_lim;
   logic             div_wrap_c, strobe_c;
   logic [DW-1:0]    s_cur, s_prev;
   logic             smp_vld;

   state_e           state, state_nxt;
   logic [AW-1:0]    wptr, wptr_nxt;
   logic [AW-1:0]    cnt, cnt_nxt;
   logic [AW-1:0]    post_cnt, post_nxt;
   logic             prev_vld, prev_vld_nxt;
   logic             force_pend, force_pend_nxt;
   logic [AW-1:0]    trig_pos_nxt;
   logic             busy_nxt, done_nxt, irq_nxt;
   logic             we_c, rise_c, fall_c, edge_hit_c;
   logic [AW-1:0]    rd_phys_c;

   // Divider setting is latched at each wrap; 0 and 1 both give a one-cycle half period.
   always_comb begin
      div_lim    = (div_cur > DIV_W'(1)) ? div_cur - DIV_W'(1) : '0;
      div_wrap_c = (div_cnt >= div_lim);
      strobe_c   = div_wrap_c && adc_clk;
   end

   always_ff @(posedge hclk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= '0;
         div_cur <= '0;
         adc_clk <= 1'b0;
      end else if (div_wrap_c) begin
         div_cnt <= '0;
         div_cur <= div_half;
         adc_clk <= ~adc_clk;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // Sample on the falling adc_clk edge; smp_vld marks the cycle the new s_cur is consumed.
   always_ff @(posedge hclk or negedge reset_n) begin
      if (!reset_n) begin
         s_cur   <= '0;
         s_prev  <= '0;
         smp_vld <= 1'b0;
      end else begin
         smp_vld <= strobe_c;
         if (strobe_c) begin
            s_prev <= s_cur;
            s_cur  <= adc_data;
         end
      end
   end

   always_comb begin
      rise_c     = (s_prev <  trig_level) && (s_cur >= trig_level);
      fall_c     = (s_prev >= trig_level) && (s_cur <  trig_level);
      edge_hit_c = prev_vld && ((trig_edge == TRIG_RISE) ? rise_c : fall_c);
   end

   always_comb begin
      state_nxt      = state;
      wptr_nxt       = wptr;
      cnt_nxt        = cnt;
      post_nxt       = post_cnt;
      prev_vld_nxt   = prev_vld;
      force_pend_nxt = force_pend;
      trig_pos_nxt   = trig_pos;
      busy_nxt       = busy;
      done_nxt       = done;
      irq_nxt        = 1'b0;
      we_c           = 1'b0;

      if (arm) begin
         state_nxt      = (pretrig == '0) ? ST_WAIT_TRIG : ST_PRE;
         wptr_nxt       = '0;
         cnt_nxt        = '0;
         prev_vld_nxt   = 1'b0;
         force_pend_nxt = 1'b0;
         busy_nxt       = 1'b1;
         done_nxt       = 1'b0;
      end else if (abort) begin
         state_nxt      = ST_IDLE;
         force_pend_nxt = 1'b0;
         busy_nxt       = 1'b0;
         done_nxt       = 1'b0;
      end else begin
         case (state)
            ST_PRE: begin
               if (smp_vld) begin
                  we_c         = 1'b1;
                  wptr_nxt     = wptr + AW'(1);
                  cnt_nxt      = cnt + AW'(1);
                  prev_vld_nxt = 1'b1;
                  if (cnt_nxt >= pretrig) state_nxt = ST_WAIT_TRIG;
               end
            end
            ST_WAIT_TRIG: begin
               // A forced trigger with no sample this cycle lands on the next written sample.
               if (smp_vld) begin
                  we_c         = 1'b1;
                  wptr_nxt     = wptr + AW'(1);
                  prev_vld_nxt = 1'b1;
                  if (edge_hit_c || force_trig || force_pend) begin
                     trig_pos_nxt   = wptr;
                     post_nxt       = AW'(DEPTH - 1) - pretrig;
                     force_pend_nxt = 1'b0;
                     state_nxt      = ST_POST;
                  end
               end else if (force_trig) begin
                  force_pend_nxt = 1'b1;
               end
            end
            ST_POST: begin
               if (post_cnt == '0) begin
                  state_nxt = ST_DONE;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
                  irq_nxt   = 1'b1;
               end else if (smp_vld) begin
                  we_c     = 1'b1;
                  wptr_nxt = wptr + AW'(1);
                  post_nxt = post_cnt - AW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge hclk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         wptr       <= '0;
         cnt        <= '0;
         post_cnt   <= '0;
         prev_vld   <= 1'b0;
         force_pend <= 1'b0;
         trig_pos   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         irq        <= 1'b0;
      end else begin
         state      <= state_nxt;
         wptr       <= wptr_nxt;
         cnt        <= cnt_nxt;
         post_cnt   <= post_nxt;
         prev_vld   <= prev_vld_nxt;
         force_pend <= force_pend_nxt;
         trig_pos   <= trig_pos_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
         irq        <= irq_nxt;
      end
   end

   // Logical index 0 is the oldest sample of the record.
   assign rd_phys_c = trig_pos - pretrig + rd_addr;

   capture_ram #(.AW(AW), .DW(DW)) u_ram (
      .clk   (hclk),
      .rst_n (reset_n),
      .we    (we_c),
      .waddr (wptr),
      .wdata (s_cur),
      .raddr (rd_phys_c),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_adc_capture.sv
// Scoreboard bench for adc_capture: sample-indexed reference model of the record.
module tb_adc_capture;
   import adc_capture_pkg::*;

   localparam int unsigned AW = 4, DW = 8, DIV_W = 8;
   localparam int unsigned DEPTH = 1 << AW;

   logic             hclk = 1'b0;
   logic             reset_n = 1'b1;
   logic [DW-1:0]    adc_data = '0;
   logic             adc_clk;
   logic [DIV_W-1:0] div_half = DIV_W'(2);
   logic             arm = 1'b0, abort = 1'b0, force_trig = 1'b0;
   logic             trig_edge = 1'b0;
   logic [DW-1:0]    trig_level = '0;
   logic [AW-1:0]    pretrig = '0;
   logic             busy, done, irq;
   logic [AW-1:0]    rd_addr = '0;
   logic [DW-1:0]    rd_data;
   logic [AW-1:0]    trig_pos;

   adc_capture #(.AW(AW), .DW(DW), .DIV_W(DIV_W)) dut (
      .hclk(hclk), .reset_n(reset_n), .adc_data(adc_data), .adc_clk(adc_clk),
      .div_half(div_half), .arm(arm), .abort(abort), .force_trig(force_trig),
      .trig_edge(trig_edge), .trig_level(trig_level), .pretrig(pretrig),
      .busy(busy), .done(done), .irq(irq), .rd_addr(rd_addr), .rd_data(rd_data),
      .trig_pos(trig_pos)
   );

   always #5 hclk = ~hclk;

   int n_checks = 0, n_pass = 0, irq_cnt = 0;
   logic [DW-1:0] stim [$];
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] mon_exp;
   logic rd_en = 1'b0, rd_pipe = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Read responses arrive one hclk after the request.
   always @(posedge hclk) rd_pipe <= rd_en;

   always @(negedge hclk) begin
      if (irq === 1'b1) irq_cnt++;
      if (rd_pipe) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL rd_unexpected: got 0x%0h with no expected entry", rd_data);
         end else begin
            mon_exp = exp_q.pop_front();
            check("rd_data", 32'(rd_data), 32'(mon_exp));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   // First sample index (counted from arm) that the trigger rules select; -1 if none.
   function automatic int find_trig(int p, logic e, logic [DW-1:0] lvl, int force_idx);
      for (int k = (p > 0) ? p : 1; k < stim.size(); k++) begin
         if (k == force_idx) return k;
         if (e == TRIG_RISE && stim[k-1] < lvl && stim[k] >= lvl) return k;
         if (e == TRIG_FALL && stim[k-1] >= lvl && stim[k] < lvl) return k;
      end
      return -1;
   endfunction

   task automatic half_len(output int n);
      logic l;
      int   guard;
      guard = 0;
      l = adc_clk;
      while (adc_clk == l && guard < 100) begin @(posedge hclk); #1; guard++; end
      l = adc_clk;
      n = 0;
      while (adc_clk == l && n < 100) begin @(posedge hclk); #1; n++; end
   endtask

   // stop_kind: 0 = run to done and read back, 1 = abort at stop_idx, 2 = reset at stop_idx.
   task automatic run_record(input int p, input logic e, input logic [DW-1:0] lvl,
                             input int force_idx, input int stop_idx, input int stop_kind);
      int t, guard;
      pretrig    = AW'(p);
      trig_edge  = e;
      trig_level = lvl;
      t = find_trig(p, e, lvl, force_idx);
      irq_cnt = 0;
      for (int k = 0; k < stim.size(); k++) begin
         if (k > 0 && done === 1'b1) break;
         @(posedge adc_clk);
         adc_data = stim[k];
         if (k == 0) begin
            arm = 1'b1;
            @(posedge hclk); #1 arm = 1'b0;
            check("done_clr_on_arm", 32'(done), 32'd0);
            check("busy_on_arm", 32'(busy), 32'd1);
         end
         if (k == force_idx) begin
            if (t == force_idx) begin
               check("busy_before_force", 32'(busy), 32'd1);
               check("done_before_force", 32'(done), 32'd0);
            end
            force_trig = 1'b1;
            @(posedge hclk); #1 force_trig = 1'b0;
         end
         if (k == stop_idx) break;
      end
      if (stop_kind == 1) begin
         abort = 1'b1;
         @(posedge hclk); #1 abort = 1'b0;
         check("abort_busy", 32'(busy), 32'd0);
         check("abort_done", 32'(done), 32'd0);
         repeat (60) @(posedge hclk);
         #1;
         check("abort_done_later", 32'(done), 32'd0);
         check("abort_irq_cnt", 32'(irq_cnt), 32'd0);
      end else if (stop_kind == 2) begin
         #3 reset_n = 1'b0;
         #1;
         check("rst_adc_clk", 32'(adc_clk), 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
         check("rst_done", 32'(done), 32'd0);
         check("rst_irq", 32'(irq), 32'd0);
         check("rst_rd_data", 32'(rd_data), 32'd0);
         check("rst_trig_pos", 32'(trig_pos), 32'd0);
         @(posedge hclk); #1 reset_n = 1'b1;
      end else begin
         guard = 0;
         while (done !== 1'b1 && guard < 400) begin @(posedge hclk); #1; guard++; end
         check("done_set", 32'(done), 32'd1);
         repeat (3) @(posedge hclk);
         #1;
         check("done_held", 32'(done), 32'd1);
         check("busy_clr", 32'(busy), 32'd0);
         check("irq_pulses", 32'(irq_cnt), 32'd1);
         check("trig_pos", 32'(trig_pos), 32'(t % DEPTH));
         if (t >= 0) begin
            for (int i = 0; i < DEPTH; i++) begin
               rd_addr = AW'(i);
               rd_en   = 1'b1;
               exp_q.push_back(stim[t - p + i]);
               @(posedge hclk); #1;
            end
         end
         rd_en = 1'b0;
         repeat (2) @(posedge hclk);
         #1;
         check("rd_drain", 32'(exp_q.size()), 32'd0);
      end
   endtask

   initial begin
      int n, p, f, len;
      logic e;
      logic [DW-1:0] lvl;

      #1 reset_n = 1'b0;
      #12;
      check("reset_adc_clk", 32'(adc_clk), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_irq", 32'(irq), 32'd0);
      check("reset_rd_data", 32'(rd_data), 32'd0);
      check("reset_trig_pos", 32'(trig_pos), 32'd0);
      @(posedge hclk); #1 reset_n = 1'b1;

      // Clock divider: half period 3, then 1 after the change settles.
      div_half = DIV_W'(3);
      repeat (3) half_len(n);
      half_len(n); check("adc_half_3a", 32'(n), 32'd3);
      half_len(n); check("adc_half_3b", 32'(n), 32'd3);
      div_half = DIV_W'(1);
      repeat (3) half_len(n);
      half_len(n); check("adc_half_1a", 32'(n), 32'd1);
      half_len(n); check("adc_half_1b", 32'(n), 32'd1);
      div_half = DIV_W'(2);

      // Rising ramp, pretrig 4: trigger on 0x80.
      stim.delete();
      for (int k = 0; k < 40; k++) stim.push_back(DW'(k * 16));
      run_record(4, TRIG_RISE, 8'h80, -1, -1, 0);

      // Falling 0x90 -> 0x70; started from DONE.
      stim.delete();
      for (int k = 0; k < 3; k++) stim.push_back(8'h90);
      for (int k = 3; k < 24; k++) stim.push_back(DW'(8'h70 - k));
      run_record(2, TRIG_FALL, 8'h80, -1, -1, 0);

      // Constant 0x70 never triggers; force_trig does.
      stim.delete();
      for (int k = 0; k < 60; k++) stim.push_back(8'h70);
      run_record(3, TRIG_FALL, 8'h80, 25, -1, 0);

      // pretrig 0, first sample 0xFF after 0x00 on the bus must not trigger.
      adc_data = 8'h00;
      repeat (10) @(posedge hclk);
      stim.delete();
      stim.push_back(8'hFF); stim.push_back(8'h00); stim.push_back(8'h90);
      for (int k = 3; k < 24; k++) stim.push_back(DW'(k * 7));
      run_record(0, TRIG_RISE, 8'h80, -1, -1, 0);

      // Several wraps before the trigger, pretrig DEPTH-1.
      div_half = DIV_W'(1);
      stim.delete();
      for (int k = 0; k < 50; k++) stim.push_back(DW'($urandom_range(0, 8'h7F)));
      for (int k = 50; k < 54; k++) stim.push_back(8'h80 + DW'(k));
      run_record(DEPTH - 1, TRIG_RISE, 8'h80, -1, -1, 0);

      // Abort, then reset, during POST.
      div_half = DIV_W'(2);
      stim.delete();
      for (int k = 0; k < 40; k++) stim.push_back(DW'(k * 16));
      run_record(4, TRIG_RISE, 8'h80, -1, 12, 1);
      run_record(4, TRIG_RISE, 8'h80, -1, 12, 2);

      // Randomized records.
      for (int r = 0; r < 8; r++) begin
         div_half = DIV_W'($urandom_range(0, 3));
         p   = int'($urandom_range(0, DEPTH - 1));
         e   = 1'($urandom_range(0, 1));
         lvl = DW'($urandom_range(8'h20, 8'hE0));
         f   = p + 1 + int'($urandom_range(0, 20));
         len = f + DEPTH + 4;
         stim.delete();
         for (int k = 0; k < len; k++) stim.push_back(DW'($urandom_range(0, 255)));
         run_record(p, e, lvl, f, -1, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
